cop0_exception_sequencer: RTL and testbench

Sequences exception and interrupt entry/exit around the COP0 register file. Samples synchronous exception requests from the commit stage and the masked interrupt vector from COP0, and selects one cause by fixed priority. It then flushes the pipeline, issues the single-cycle exception-occurred strobe with cause code, branch-delay flag and EPC value to COP0, and redirects the PC to the handler. It also handles ERET redirection. It sits between the pipeline control unit, the PC mux and the COP0 register block.

---
 rtl/cop0_exception_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cop0_exception_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cop0_exception_sequencer.sv
// cop0_exception_sequencer
// Sequences exception/interrupt entry and ERET exit around the COP0 register
// file: picks one cause by fixed priority, flushes the pipeline, strobes the
// cause/BD/EPC into COP0 and redirects the PC to the handler.
//
// Ports:
//   iCLK, iCLR            clock, synchronous active-high reset
//   iValid, iPC, iBranchDelay, iAdEL..iBp, iEret, iEretTarget  commit stage
//   iInterruptMask, iExcLevel                                  COP0 status
//   oStall, oFlush        pipeline control
//   oExcOccurred, oExcCode, oBranchDelay, oEPC                 COP0 write side
//   oPCLoad, oPCTarget    PC mux redirect
//   oBusy                 sequencer not idle
//   oExcCount             exceptions taken (only with COP0_EXC_STATS_EN)
//
// Optional feature macro: COP0_EXC_STATS_EN (saturating exception counter).
module cop0_exception_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] HANDLER_ADDR = 32'h80000180
) (
    input  logic        iCLK,
    input  logic        iCLR,
    input  logic        iValid,
    input  logic [31:0] iPC,
    input  logic        iBranchDelay,
    input  logic        iAdEL,
    input  logic        iAdES,
    input  logic        iRI,
    input  logic        iOv,
    input  logic        iSys,
    input  logic        iBp,
    input  logic [7:0]  iInterruptMask,
    input  logic        iExcLevel,
    input  logic        iEret,
    input  logic [31:0] iEretTarget,
    output logic        oStall,
    output logic        oFlush,
    output logic        oExcOccurred,
    output logic [4:0]  oExcCode,
    output logic        oBranchDelay,
    output logic [31:0] oEPC,
    output logic        oPCLoad,
    output logic [31:0] oPCTarget,
    output logic        oBusy,
    output logic [15:0] oExcCount
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CODE_W = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_COMMIT = 3'd2,
        S_VECTOR = 3'd3,
        S_ERET   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                bd_q, bd_d;
    logic [31:0]         epc_q, epc_d;
    logic [31:0]         eret_tgt_q, eret_tgt_d;

    logic                stall_d, flush_d, exc_d, pcload_d, busy_d;
    logic [31:0]         target_d;

    logic                sync_exc_c;
    logic                irq_c;
    logic [CODE_W-1:0]   sync_code_c;

    // Fixed-priority cause selection among synchronous requests
    always_comb begin
        sync_exc_c  = iValid & (iAdEL | iAdES | iRI | iOv | iSys | iBp);
        irq_c       = ~iExcLevel & (|iInterruptMask);
        sync_code_c = CODE_W'(0);
        if      (iAdEL) sync_code_c = CODE_W'(4);
        else if (iAdES) sync_code_c = CODE_W'(5);
        else if (iRI)   sync_code_c = CODE_W'(10);
        else if (iOv)   sync_code_c = CODE_W'(12);
        else if (iSys)  sync_code_c = CODE_W'(8);
        else if (iBp)   sync_code_c = CODE_W'(9);
    end

    // Next-state logic; outputs are precomputed from the next state so the
    // registered outputs line up with the state they describe
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        code_d     = code_q;
        bd_d       = bd_q;
        epc_d      = epc_q;
        eret_tgt_d = eret_tgt_q;

        case (state_q)
            S_IDLE: begin
                // Sync exception beats ERET; ERET beats a pending interrupt
                if (sync_exc_c) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    code_d  = sync_code_c;
                    bd_d    = iBranchDelay;
                    epc_d   = iBranchDelay ? (iPC - 32'd4) : iPC;
                end else if (iValid && iEret) begin
                    state_d    = S_ERET;
                    eret_tgt_d = iEretTarget;
                end else if (irq_c) begin
                    state_d = S_FLUSH;
                    cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
                    code_d  = CODE_W'(0);
                    bd_d    = iBranchDelay;
                    epc_d   = iPC - 32'd4;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_W'(0)) state_d = S_COMMIT;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            S_COMMIT: state_d = S_VECTOR;
            S_VECTOR: state_d = S_IDLE;
            S_ERET:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        stall_d  = (state_d == S_FLUSH) || (state_d == S_COMMIT) || (state_d == S_VECTOR);
        flush_d  = (state_d == S_FLUSH) || (state_d == S_ERET);
        exc_d    = (state_d == S_COMMIT);
        pcload_d = (state_d == S_VECTOR) || (state_d == S_ERET);
        busy_d   = (state_d != S_IDLE);
        target_d = 32'd0;
        if (state_d == S_VECTOR)    target_d = HANDLER_ADDR;
        else if (state_d == S_ERET) target_d = eret_tgt_d;
    end

    // State, latched fields and registered outputs
    always_ff @(posedge iCLK) begin
        if (iCLR) begin
            state_q      <= S_IDLE;
            cnt_q        <= CNT_W'(0);
            code_q       <= CODE_W'(0);
            bd_q         <= 1'b0;
            epc_q        <= 32'd0;
            eret_tgt_q   <= 32'd0;
            oStall       <= 1'b0;
            oFlush       <= 1'b0;
            oExcOccurred <= 1'b0;
            oPCLoad      <= 1'b0;
            oPCTarget    <= 32'd0;
            oBusy        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            code_q       <= code_d;
            bd_q         <= bd_d;
            epc_q        <= epc_d;
            eret_tgt_q   <= eret_tgt_d;
            oStall       <= stall_d;
            oFlush       <= flush_d;
            oExcOccurred <= exc_d;
            oPCLoad      <= pcload_d;
            oPCTarget    <= target_d;
            oBusy        <= busy_d;
        end
    end

    // Latched fields are already registers; they hold between commits
    assign oExcCode     = code_q;
    assign oBranchDelay = bd_q;
    assign oEPC         = epc_q;

`ifdef COP0_EXC_STATS_EN
    logic [15:0] exc_count_q;

    // Saturating count of committed exceptions
    always_ff @(posedge iCLK) begin
        if (iCLR)
            exc_count_q <= 16'd0;
        else if ((state_q == S_COMMIT) && (exc_count_q != 16'hFFFF))
            exc_count_q <= exc_count_q + 16'd1;
    end

    assign oExcCount = exc_count_q;
`else
    assign oExcCount = 16'h0000;
`endif

endmodule

// File: tb/tb_cop0_exception_sequencer.sv
// Scoreboard bench for cop0_exception_sequencer: stimulus pushes expected
// commit/redirect events, a negedge monitor pops and compares them.
module tb_cop0_exception_sequencer;

    localparam int unsigned FC      = 2;
    localparam logic [31:0] HANDLER = 32'h80000180;

    logic        iCLK = 1'b0;
    logic        iCLR;
    logic        iValid;
    logic [31:0] iPC;
    logic        iBranchDelay;
    logic        iAdEL, iAdES, iRI, iOv, iSys, iBp;
    logic [7:0]  iInterruptMask;
    logic        iExcLevel;
    logic        iEret;
    logic [31:0] iEretTarget;
    logic        oStall, oFlush, oExcOccurred, oBranchDelay, oPCLoad, oBusy;
    logic [4:0]  oExcCode;
    logic [31:0] oEPC, oPCTarget;
    logic [15:0] oExcCount;

    cop0_exception_sequencer #(.FLUSH_CYCLES(FC), .HANDLER_ADDR(HANDLER)) dut (
        .iCLK(iCLK), .iCLR(iCLR), .iValid(iValid), .iPC(iPC),
        .iBranchDelay(iBranchDelay), .iAdEL(iAdEL), .iAdES(iAdES), .iRI(iRI),
        .iOv(iOv), .iSys(iSys), .iBp(iBp), .iInterruptMask(iInterruptMask),
        .iExcLevel(iExcLevel), .iEret(iEret), .iEretTarget(iEretTarget),
        .oStall(oStall), .oFlush(oFlush), .oExcOccurred(oExcOccurred),
        .oExcCode(oExcCode), .oBranchDelay(oBranchDelay), .oEPC(oEPC),
        .oPCLoad(oPCLoad), .oPCTarget(oPCTarget), .oBusy(oBusy),
        .oExcCount(oExcCount)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  code;
        logic        bd;
        logic [31:0] epc;
        int          at;
    } exc_t;

    typedef struct {
        logic [31:0] tgt;
        logic        flush;
        logic        chk_stall;
        int          at;
    } pc_t;

    exc_t exc_q[$];
    pc_t  pc_q[$];
    int   tests = 0;
    int   fails = 0;
    int   flush_run = 0;
    int   exp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_reqs();
        iValid = 0; iBranchDelay = 0; iAdEL = 0; iAdES = 0; iRI = 0; iOv = 0;
        iSys = 0; iBp = 0; iInterruptMask = 8'h00; iEret = 0;
    endtask

    // Let the prepared request be sampled, return the detection cycle stamp
    task automatic detect(output int d);
        @(posedge iCLK);
        #1;
        d = cyc;
        clear_reqs();
    endtask

    task automatic exp_exc(input logic [4:0] code, input logic bd, input logic [31:0] epc, input int d);
        exc_q.push_back('{code: code, bd: bd, epc: epc, at: d + FC});
        pc_q.push_back('{tgt: HANDLER, flush: 1'b0, chk_stall: 1'b1, at: d + FC + 1});
        if (exp_cnt < 65535) exp_cnt++;
    endtask

    task automatic exp_eret(input logic [31:0] tgt, input int d);
        pc_q.push_back('{tgt: tgt, flush: 1'b1, chk_stall: 1'b0, at: d});
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64; i++) begin
            @(negedge iCLK);
            if (!oBusy) return;
        end
        tests++;
        fails++;
        $display("FAIL wait_idle: oBusy still 1 after 64 cycles expected 0");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".stall"},  32'(oStall), 32'd0);
        chk({tag, ".flush"},  32'(oFlush), 32'd0);
        chk({tag, ".exc"},    32'(oExcOccurred), 32'd0);
        chk({tag, ".code"},   32'(oExcCode), 32'd0);
        chk({tag, ".bd"},     32'(oBranchDelay), 32'd0);
        chk({tag, ".epc"},    oEPC, 32'd0);
        chk({tag, ".pcload"}, 32'(oPCLoad), 32'd0);
        chk({tag, ".target"}, oPCTarget, 32'd0);
        chk({tag, ".busy"},   32'(oBusy), 32'd0);
        chk({tag, ".count"},  32'(oExcCount), 32'd0);
    endtask

    // Monitor: compare every strobe against the head of its queue
    always @(negedge iCLK) begin
        if (!oBusy) flush_run = 0;
        else if (oFlush && !oPCLoad) flush_run++;

        if (oExcOccurred) begin
            if (exc_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_exc: got code %0d at cyc %0d expected none", oExcCode, cyc);
            end else begin
                exc_t e;
                e = exc_q.pop_front();
                chk("exc.code",  32'(oExcCode), 32'(e.code));
                chk("exc.bd",    32'(oBranchDelay), 32'(e.bd));
                chk("exc.epc",   oEPC, e.epc);
                chk("exc.cycle", 32'(cyc), 32'(e.at));
                chk("exc.flush_len", 32'(flush_run), 32'(FC));
                chk("exc.stall", 32'(oStall), 32'd1);
                chk("exc.flush_off", 32'(oFlush), 32'd0);
            end
        end

        if (oPCLoad) begin
            if (pc_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pcload: got target %h at cyc %0d expected none", oPCTarget, cyc);
            end else begin
                pc_t p;
                p = pc_q.pop_front();
                chk("pc.target", oPCTarget, p.tgt);
                chk("pc.flush",  32'(oFlush), 32'(p.flush));
                chk("pc.cycle",  32'(cyc), 32'(p.at));
                if (p.chk_stall) chk("pc.stall", 32'(oStall), 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d;
        clear_reqs();
        iPC = 32'd0; iExcLevel = 0; iEretTarget = 32'd0;
        iCLR = 1;
        repeat (2) @(posedge iCLK);
        #1;
        check_all_zero("reset");
        @(negedge iCLK);
        iCLR = 0;

        // Reset while flushing: no strobe may follow
        @(negedge iCLK);
        iValid = 1; iOv = 1; iPC = 32'h00400010;
        detect(d);
        iCLR = 1;
        @(posedge iCLK);
        #1;
        check_all_zero("midflush_reset");
        exp_cnt = 0;
        @(negedge iCLK);
        iCLR = 0;
        repeat (5) @(negedge iCLK);

        // Overflow, no delay slot
        iValid = 1; iOv = 1; iPC = 32'h00400010;
        detect(d);
        exp_exc(5'd12, 1'b0, 32'h00400010, d);
        wait_idle();

        // RI beats Sys and interrupt; delay slot rewinds EPC
        iValid = 1; iRI = 1; iSys = 1; iInterruptMask = 8'h01;
        iBranchDelay = 1; iPC = 32'h00400024;
        detect(d);
        exp_exc(5'd10, 1'b1, 32'h00400020, d);
        wait_idle();

        // Interrupt blocked by EXL, then taken once EXL drops
        iInterruptMask = 8'h80; iExcLevel = 1; iPC = 32'h00400100;
        repeat (3) begin
            @(negedge iCLK);
            chk("irq_exl_blocked", 32'(oBusy), 32'd0);
        end
        iExcLevel = 0;
        detect(d);
        exp_exc(5'd0, 1'b0, 32'h004000FC, d);
        wait_idle();

        // ERET redirect
        iValid = 1; iEret = 1; iEretTarget = 32'h00400104;
        detect(d);
        exp_eret(32'h00400104, d);
        wait_idle();

        // ERET with AdES: exception wins, no ERET redirect
        iValid = 1; iEret = 1; iAdES = 1; iPC = 32'h00400200;
        iEretTarget = 32'h00400104;
        detect(d);
        exp_exc(5'd5, 1'b0, 32'h00400200, d);
        wait_idle();

        // ERET with interrupt: ERET first, interrupt two edges later
        iValid = 1; iEret = 1; iEretTarget = 32'h00400500;
        iInterruptMask = 8'h04; iPC = 32'h00400600;
        @(posedge iCLK);
        #1;
        d = cyc;
        iValid = 0; iEret = 0;
        exp_eret(32'h00400500, d);
        exp_exc(5'd0, 1'b0, 32'h004005FC, d + 2);
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iInterruptMask = 8'h00;
        wait_idle();

        // Back-to-back: AdEL at PC 0 in a delay slot, then Bp right after VECTOR
        iValid = 1; iAdEL = 1; iAdES = 1; iBranchDelay = 1; iPC = 32'h00000000;
        detect(d);
        exp_exc(5'd4, 1'b1, 32'hFFFFFFFC, d);
        wait_idle();
        iValid = 1; iBp = 1; iPC = 32'h00400300;
        detect(d);
        exp_exc(5'd9, 1'b0, 32'h00400300, d);
        wait_idle();

`ifdef COP0_EXC_STATS_EN
        chk("exc_count", 32'(oExcCount), 32'(exp_cnt));
        force dut.exc_count_q = 16'hFFFF;
        #1;
        release dut.exc_count_q;
        @(negedge iCLK);
        iValid = 1; iSys = 1; iPC = 32'h00400400;
        detect(d);
        exp_exc(5'd8, 1'b0, 32'h00400400, d);
        wait_idle();
        chk("exc_count_saturate", 32'(oExcCount), 32'h0000FFFF);
`else
        chk("exc_count_tied", 32'(oExcCount), 32'd0);
`endif

        repeat (4) @(negedge iCLK);
        chk("final_busy", 32'(oBusy), 32'd0);
        chk("exc_queue_drained", 32'(exc_q.size()), 32'd0);
        chk("pc_queue_drained", 32'(pc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
